// File: rtl/laser_ctrl_pkg.sv
// laser_ctrl_pkg: shared state encoding and default timing constants for the laser burst sequencer
package laser_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, RAMP_UP, SETTLE, BURST, RAMP_DOWN, FAULT} state_t;
    localparam int unsigned DEF_PERIOD_CYCLES = 1000002;
    localparam int unsigned DEF_RAMP_DIV      = 4096;
    localparam int unsigned DEF_SETTLE_CYCLES = 250000;
endpackage

// File: rtl/duty_ramp.sv
// duty_ramp: step timer plus saturating up/down duty accumulator
//   clock, reset     : sole clock, synchronous active-high reset
//   clr              : force duty and timer to 0 (fault entry)
//   restart          : restart the step timer (state change)
//   up / down        : ramp direction enables; timer idles at 0 when neither is set
//   step, target     : duty increment and ramp-up ceiling
//   tick             : high on the cycle whose edge applies a step
//   nxt              : duty value that the coming step will produce
//   duty             : current duty
module duty_ramp
    import laser_ctrl_pkg::*;
#(
    parameter int unsigned DIV = DEF_RAMP_DIV
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clr,
    input  logic        restart,
    input  logic        up,
    input  logic        down,
    input  logic [11:0] step,
    input  logic [11:0] target,
    output logic        tick,
    output logic [11:0] nxt,
    output logic [11:0] duty
);
    logic [31:0] tmr;
    logic [12:0] sum;
    always_comb begin
        tick = (up || down) && tmr == DIV - 1;
        sum  = {1'b0, duty} + {1'b0, step};
        // 13-bit sum so a large step saturates at target instead of wrapping
        nxt  = up ? (sum >= {1'b0, target} ? target : sum[11:0])
                  : (duty > step ? duty - step : 12'd0);
    end
    always_ff @(posedge clock) begin
        if (reset || clr) begin
            tmr  <= '0;
            duty <= '0;
        end else begin
            tmr <= (restart || tick || !(up || down)) ? '0 : tmr + 32'd1;
            if (tick)
                duty <= nxt;
        end
    end
endmodule

// File: rtl/laser_burst_sequencer.sv
// laser_burst_sequencer: ramps laser voltage up, settles, fires a counted pulse burst, ramps down
//   clock, reset          : sole clock, synchronous active-high reset
//   start, abort          : burst request (IDLE only) / orderly early end
//   interlock_ok          : safety interlock, low forces FAULT from any active state
//   fault_clr             : fault acknowledge
//   burst_count, pulse_length_cfg, duty_target, ramp_step : burst configuration, latched on start
//   LSR_ON, stop, PULSE_LENGTH, PWM_DUTY : pulse generator / voltage controls
//   busy, done, fault, pulses_done       : status
module laser_burst_sequencer
    import laser_ctrl_pkg::*;
#(
    parameter int unsigned PERIOD_CYCLES = DEF_PERIOD_CYCLES,
    parameter int unsigned RAMP_DIV      = DEF_RAMP_DIV,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        interlock_ok,
    input  logic        fault_clr,
    input  logic [15:0] burst_count,
    input  logic [31:0] pulse_length_cfg,
    input  logic [11:0] duty_target,
    input  logic [11:0] ramp_step,
    output logic        LSR_ON,
    output logic        stop,
    output logic [31:0] PULSE_LENGTH,
    output logic [31:0] PWM_DUTY,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [15:0] pulses_done
);
    state_t      state, state_nxt;
    logic [15:0] count_q, pulses;
    logic [31:0] len_q, cnt;
    logic [11:0] target_q, step_q, duty, nxt;
    logic        tick, done_q, accept, settle_end, period_wrap, last_pulse;

    always_comb begin
        accept      = state == IDLE && start && interlock_ok;
        settle_end  = cnt == SETTLE_CYCLES - 1;
        period_wrap = cnt == PERIOD_CYCLES - 1;
        last_pulse  = period_wrap && pulses + 16'd1 == count_q;
    end

    always_ff @(posedge clock)
        state <= reset ? IDLE : state_nxt;

    // interlock outranks abort, and abort outranks normal phase completion
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (accept && burst_count != '0) state_nxt = RAMP_UP;
            RAMP_UP:   state_nxt = !interlock_ok ? FAULT : abort ? RAMP_DOWN
                                 : (tick && nxt == target_q) ? SETTLE : RAMP_UP;
            SETTLE:    state_nxt = !interlock_ok ? FAULT : abort ? RAMP_DOWN
                                 : settle_end ? BURST : SETTLE;
            BURST:     state_nxt = !interlock_ok ? FAULT : (abort || last_pulse) ? RAMP_DOWN : BURST;
            RAMP_DOWN: state_nxt = !interlock_ok ? FAULT : (tick && nxt == '0) ? IDLE : RAMP_DOWN;
            FAULT:     if (fault_clr && interlock_ok) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    duty_ramp #(.DIV(RAMP_DIV)) u_ramp (
        .clock   (clock),
        .reset   (reset),
        .clr     (state_nxt == FAULT),
        .restart (state_nxt != state),
        .up      (state == RAMP_UP),
        .down    (state == RAMP_DOWN),
        .step    (step_q),
        .target  (target_q),
        .tick    (tick),
        .nxt     (nxt),
        .duty    (duty)
    );

    // cnt serves as settle timer and pulse-period counter; it restarts on every state change
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q  <= '0;
            len_q    <= '0;
            target_q <= '0;
            step_q   <= '0;
            cnt      <= '0;
            pulses   <= '0;
            done_q   <= 1'b0;
        end else begin
            cnt    <= (state_nxt != state || (state == BURST && period_wrap)) ? '0 : cnt + 32'd1;
            done_q <= (accept && burst_count == '0) || (state == RAMP_DOWN && state_nxt == IDLE);
            if (accept) begin
                count_q  <= burst_count;
                len_q    <= pulse_length_cfg;
                target_q <= duty_target;
                step_q   <= ramp_step == '0 ? 12'd1 : ramp_step;
                pulses   <= '0;
            end else if (state == BURST && period_wrap && interlock_ok)
                pulses <= pulses + 16'd1;
        end
    end

    always_comb begin
        LSR_ON       = state == BURST;
        stop         = state != BURST;
        PULSE_LENGTH = state == BURST ? len_q : '0;
        PWM_DUTY     = {20'd0, duty};
        busy         = state != IDLE && state != FAULT;
        done         = done_q;
        fault        = state == FAULT;
        pulses_done  = pulses;
    end
endmodule

// File: tb/tb_laser_burst_sequencer.sv
// tb_laser_burst_sequencer: randomized burst scenarios checked against a timeline model
module tb_laser_burst_sequencer;
    localparam int P = 100, DIV = 8, S = 20;
    logic        clock = 1'b0;
    logic        reset, start, abort, interlock_ok, fault_clr;
    logic [15:0] burst_count;
    logic [31:0] pulse_length_cfg;
    logic [11:0] duty_target, ramp_step;
    logic        LSR_ON, stop, busy, done, fault;
    logic [31:0] PULSE_LENGTH, PWM_DUTY;
    logic [15:0] pulses_done;
    int          n_cmp = 0, n_bad = 0;
    int          t, s, cnt;
    logic [31:0] len;

    laser_burst_sequencer #(.PERIOD_CYCLES(P), .RAMP_DIV(DIV), .SETTLE_CYCLES(S)) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort), .interlock_ok(interlock_ok),
        .fault_clr(fault_clr), .burst_count(burst_count), .pulse_length_cfg(pulse_length_cfg),
        .duty_target(duty_target), .ramp_step(ramp_step), .LSR_ON(LSR_ON), .stop(stop),
        .PULSE_LENGTH(PULSE_LENGTH), .PWM_DUTY(PWM_DUTY), .busy(busy), .done(done),
        .fault(fault), .pulses_done(pulses_done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // phases: 0 idle with done, 1 ramp up, 2 settle, 3 burst, 4 ramp down, 5 idle, 6 fault, 7 just reset
    function automatic int nsteps(input int d);
        return d == 0 ? 1 : (d + s - 1) / s;
    endfunction

    function automatic void down(input int n, input int r, input int d0, output int ph, output int duty);
        int k = n - r;
        int m = nsteps(d0) * DIV;
        ph   = k < m ? 4 : k == m ? 0 : 5;
        duty = k < m ? d0 - (k / DIV) * s : 0;
        if (duty < 0) duty = 0;
    endfunction

    function automatic void fwd(input int n, output int ph, output int duty, output int p);
        int u  = nsteps(t) * DIV;
        int b0 = u + S;
        int r0 = b0 + cnt * P;
        p    = 0;
        duty = t;
        if (cnt == 0) begin
            ph   = n == 0 ? 0 : 5;
            duty = 0;
        end else if (n < u) begin
            ph   = 1;
            duty = (n / DIV) * s < t ? (n / DIV) * s : t;
        end else if (n < b0) ph = 2;
        else if (n < r0) begin
            ph = 3;
            p  = (n - b0) / P;
        end else begin
            down(n, r0, t, ph, duty);
            p = cnt;
        end
    endfunction

    task automatic check_outputs(input int ph, input int duty, input int p);
        check("duty", PWM_DUTY, duty);
        check("lsr_on", LSR_ON, ph == 3);
        check("stop", stop, ph != 3);
        check("busy", busy, ph >= 1 && ph <= 4);
        check("done", done, ph == 0);
        check("fault", fault, ph == 6);
        check("pulses", pulses_done, p);
        if (ph == 3) check("plen", PULSE_LENGTH, len);
        if (ph == 7) check("plen_rst", PULSE_LENGTH, 0);
    endtask

    // mode: 0 plain, 1 abort at ev, 2 interlock drop at ev, 3 reset at ev; ev < 0 picks a random cycle
    task automatic run(input int mode, input int ev_in, input int tgt, input int stp, input int c, output bit hit);
        int ph, duty, p, fph, fd, fp, ev, lsr_n, done_n;
        bit fin;
        t   = tgt;
        s   = stp == 0 ? 1 : stp;
        cnt = c;
        len = $urandom;
        ev  = ev_in >= 0 ? ev_in : int'($urandom_range(2 * nsteps(t) * DIV + S + c * P));
        burst_count = 16'(c); duty_target = 12'(tgt); ramp_step = 12'(stp);
        pulse_length_cfg = len; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        hit = 0; fin = 0; lsr_n = 0; done_n = 0;
        for (int n = 0; n < 8000; n++) begin
            fwd(n, ph, duty, p);
            if (hit) begin
                if (mode == 1) begin
                    fwd(ev + 1, fph, fd, fp);
                    down(n, ev + 1, fd, ph, duty);
                    p = fp;
                end else if (mode == 2) begin
                    fwd(ev, fph, fd, p);
                    ph = 6; duty = 0;
                end else begin
                    ph = 7; duty = 0; p = 0;
                end
            end
            check_outputs(ph, duty, p);
            lsr_n  += int'(LSR_ON);
            done_n += int'(done);
            fin = ph == 5 || ph == 7 || (ph == 6 && n >= ev + 4);
            if (fin) break;
            if (n == ev && !hit) begin
                hit = mode == 1 ? (ph inside {[1:3]}) : (mode >= 2 && ph inside {[1:4]});
                abort = mode == 1;
                interlock_ok = !(mode == 2 && hit);
                reset = mode == 3 && hit;
            end
            start     = (ph inside {[1:4], 6}) && $urandom_range(15) == 0;
            fault_clr = (ph inside {[1:4]}) && $urandom_range(15) == 0;
            burst_count = 16'($urandom); duty_target = 12'($urandom);
            ramp_step = 12'($urandom); pulse_length_cfg = $urandom;
            @(posedge clock); #1;
            abort = 0; reset = 0; start = 0; fault_clr = 0;
        end
        check("finished", fin, 1);
        if (!hit) begin
            check("lsr_cycles", lsr_n, c * P);
            check("done_count", done_n, 1);
        end else if (mode == 1)
            check("abort_done_count", done_n, 1);
    endtask

    task automatic fault_seq();
        fault_clr = 1; @(posedge clock); #1; fault_clr = 0;
        check("fault_hold_il_low", fault, 1);
        interlock_ok = 1; start = 1; @(posedge clock); #1; start = 0;
        check("fault_start_ignored", fault, 1);
        check("fault_busy", busy, 0);
        fault_clr = 1; @(posedge clock); #1; fault_clr = 0;
        check("fault_exit", fault, 0);
        check("exit_busy", busy, 0);
        check("exit_done", done, 0);
        check("exit_duty", PWM_DUTY, 0);
        @(posedge clock); #1;
        check("no_done", done, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        bit h;
        int mode;
        reset = 1; start = 0; abort = 0; interlock_ok = 1; fault_clr = 0;
        burst_count = 0; pulse_length_cfg = 0; duty_target = 0; ramp_step = 0;
        repeat (3) @(posedge clock);
        #1;
        len = 0;
        check_outputs(7, 0, 0);
        reset = 0;
        interlock_ok = 0; start = 1; burst_count = 0;
        @(posedge clock); #1;
        start = 0; interlock_ok = 1;
        check("idle_il_low_busy", busy, 0);
        check("idle_il_low_done", done, 0);
        run(0, 0, 64, 16, 3, h);
        run(0, 0, 50, 16, 2, h);
        run(2, 162, 64, 16, 3, h);
        if (h) fault_seq();
        run(1, 40, 64, 16, 3, h);
        run(0, 0, 40, 16, 0, h);
        run(0, 0, 5, 0, 1, h);
        run(3, 100, 64, 16, 3, h);
        run(0, 0, 64, 16, 3, h);
        repeat (24) begin
            mode = $urandom_range(3);
            run(mode, -1, $urandom_range(120), $urandom_range(40), $urandom_range(3), h);
            if (mode == 2 && h) fault_seq();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/laser_burst_sequencer.md
LASER_BURST_SEQUENCER -- requirements
Module: laser_burst_sequencer

Interface
REQ-001 Parameter PERIOD_CYCLES, default 1000002, SHALL be the laser pulse period in clock cycles and SHALL match the downstream pulse generator frame.
REQ-002 Parameter RAMP_DIV, default 4096, SHALL be the cycles between duty ramp steps (one PWM frame).
REQ-003 Parameter SETTLE_CYCLES, default 250000, SHALL be the voltage settle time after ramp-up.
REQ-004 clock  in  1  sole clock; all logic on posedge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  single-cycle burst request; honoured only in IDLE.
REQ-007 abort  in  1  single-cycle request to end the burst early through an orderly ramp-down.
REQ-008 interlock_ok  in  1  safety interlock; low means the laser must not fire.
REQ-009 fault_clr  in  1  single-cycle fault acknowledge.
REQ-010 burst_count  in  16  number of pulses per burst.
REQ-011 pulse_length_cfg  in  32  pulse high time in cycles.
REQ-012 duty_target  in  12  operating PWM duty.
REQ-013 ramp_step  in  12  duty increment per ramp step.
REQ-014 LSR_ON  out  1  laser enable to the pulse generator.
REQ-015 stop  out  1  hard pulse inhibit to the pulse generator.
REQ-016 PULSE_LENGTH  out  32  pulse length to the pulse generator.
REQ-017 PWM_DUTY  out  32  laser voltage duty; bits [31:12] are always 0.
REQ-018 busy  out  1  high in every state except IDLE and FAULT.
REQ-019 done  out  1  one-cycle strobe on burst completion.
REQ-020 fault  out  1  high while in FAULT.
REQ-021 pulses_done  out  16  pulses issued in the current or most recent burst.

Function
REQ-022 States SHALL be IDLE, RAMP_UP, SETTLE, BURST, RAMP_DOWN and FAULT, all registered.
REQ-023 In IDLE, start with interlock_ok=1 SHALL do the following in the same edge: latch burst_count, pulse_length_cfg, duty_target and ramp_step (a ramp_step of 0 is latched as 1); clear pulses_done; enter RAMP_UP.
REQ-024 start with latched burst_count=0 SHALL pulse done the next cycle and remain in IDLE.
REQ-025 In RAMP_UP, every RAMP_DIV cycles PWM_DUTY SHALL become min(duty+step, target), computed 13 bits wide with no wrap; reaching target SHALL enter SETTLE.
REQ-026 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then enter BURST with the period counter at 0.
REQ-027 In BURST: LSR_ON=1, stop=0, PULSE_LENGTH=latched length.
REQ-028 In BURST, each PERIOD_CYCLES wrap SHALL increment pulses_done.
REQ-029 When pulses_done reaches the latched count, the block SHALL enter RAMP_DOWN on that edge.
REQ-030 Outside BURST: LSR_ON=0 and stop=1.
REQ-031 In RAMP_DOWN, every RAMP_DIV cycles PWM_DUTY SHALL become max(duty-step, 0); reaching 0 SHALL pulse done and enter IDLE.
REQ-032 abort in RAMP_UP, SETTLE or BURST SHALL enter RAMP_DOWN on the next edge; done SHALL still pulse, and pulses_done SHALL hold its count.
REQ-033 abort in IDLE, RAMP_DOWN or FAULT SHALL be ignored.
REQ-034 interlock_ok=0 in any state except IDLE SHALL enter FAULT on the next edge, with PWM_DUTY=0, LSR_ON=0 and stop=1 in that same cycle; interlock takes priority over abort and over completion.
REQ-035 FAULT SHALL exit to IDLE only on fault_clr with interlock_ok=1; no done pulse is issued.
REQ-036 start and fault_clr arriving in non-accepting states SHALL be ignored, not queued.

Reset
REQ-037 reset SHALL force IDLE, LSR_ON=0, stop=1, PULSE_LENGTH=0, PWM_DUTY=0, busy=0, done=0, fault=0 and pulses_done=0, and SHALL clear all counters and latched configuration.
REQ-038 reset asserted mid-burst SHALL take effect on the next edge, with no ramp-down.

Structure
REQ-039 The state encoding and the default PERIOD_CYCLES, RAMP_DIV and SETTLE_CYCLES constants SHALL reside in the shared package laser_ctrl_pkg.
REQ-040 Duty ramping SHALL be one sub-module, duty_ramp: a step timer plus a saturating up/down accumulator.

Verification
REQ-041 PERIOD_CYCLES=100, RAMP_DIV=8, SETTLE_CYCLES=20; start with count=3, target=64, step=16 -> PWM_DUTY steps 16/32/48/64 at 8-cycle spacing; LSR_ON high for exactly 300 cycles; pulses_done=3; ramp to 0; one done pulse.
REQ-042 target=50, step=16 -> duty sequence 16, 32, 48, 50 (saturates, no overshoot); ramp-down 34, 18, 2, 0.
REQ-043 interlock_ok dropped in BURST at pulse 1 -> next cycle FAULT, PWM_DUTY=0, LSR_ON=0; start ignored; fault_clr with interlock_ok=1 -> IDLE; no done pulse.
REQ-044 abort in SETTLE -> RAMP_DOWN next edge; LSR_ON never asserts; done pulses; pulses_done=0.
REQ-045 start with burst_count=0 -> done one cycle later, busy stays 0; ramp_step=0 -> ramp advances by 1 per step.
REQ-046 reset asserted in BURST -> all outputs at reset values on the next edge; a fresh start runs a normal burst.
